fft_frame_scheduler: RTL and testbench

- Ping-pong frame scheduler in front of the BRAM read/zero-pad block of the correlation path.
- Accepts an AXI-Stream sample stream and writes N2-sample frames alternately into two BRAM banks.
- When a bank holds a complete frame, it pulses start to the reader with that bank selected.
- It frees the bank on the reader's done, so input capture and FFT feed overlap.

---
 rtl/fft_frame_scheduler_if.sv | 27 ++
 rtl/fft_frame_scheduler.sv | 100 ++++++++++
 tb/tb_fft_frame_scheduler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_scheduler_if.sv
// fft_frame_scheduler_if: sample stream, BRAM write port and reader handshake of the ping-pong frame scheduler
interface fft_frame_scheduler_if #(
  parameter int DW = 32
);
  logic [12:0]   N2;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          wr_en;
  logic          wr_bank;
  logic [12:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_start;
  logic          rd_bank;
  logic [12:0]   rd_n2;
  logic          rd_done;
  logic [15:0]   frame_cnt;
  logic          busy;
  modport master (
    output N2, s_tdata, s_tvalid, rd_done,
    input  s_tready, wr_en, wr_bank, wr_addr, wr_data, rd_start, rd_bank, rd_n2, frame_cnt, busy
  );
  modport slave (
    input  N2, s_tdata, s_tvalid, rd_done,
    output s_tready, wr_en, wr_bank, wr_addr, wr_data, rd_start, rd_bank, rd_n2, frame_cnt, busy
  );
endinterface

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: captures sample frames alternately into two BRAM banks and hands full banks to the reader
module fft_frame_scheduler #(
  parameter int NFFT = 256,
  parameter int DW   = 32
) (
  input logic                  aclk,
  input logic                  aresetn,
  fft_frame_scheduler_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_t;
  typedef enum logic {IDLE, BUSY} rd_t;
  localparam logic [12:0] NFFT_W = 13'(NFFT);
  bank_t         bank_q [2];
  bank_t         bank_d [2];
  logic [12:0]   len_q [2];
  logic [12:0]   len_d [2];
  logic [12:0]   wr_cnt_q, wr_cnt_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  rd_t           rd_st_q, rd_st_d;
  logic          rd_start_q, rd_start_d;
  logic          rd_bank_q, rd_bank_d;
  logic [12:0]   rd_n2_q, rd_n2_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [12:0]   n2_eff, cur_len;
  logic          ready, hs;
  logic [DW-1:0] data;
  assign n2_eff  = (bus.N2 == '0 || bus.N2 > NFFT_W) ? NFFT_W : bus.N2;
  // the frame length is taken from N2 only on the first write into a bank
  assign cur_len = (wr_cnt_q == '0) ? n2_eff : len_q[wr_sel_q];
  assign ready   = aresetn && (bank_q[wr_sel_q] == EMPTY || bank_q[wr_sel_q] == FILLING);
  assign hs      = bus.s_tvalid && ready;
  assign data    = bus.s_tdata;
  assign bus.s_tready  = ready;
  assign bus.wr_en     = hs;
  assign bus.wr_bank   = wr_sel_q;
  assign bus.wr_addr   = wr_cnt_q;
  assign bus.wr_data   = data;
  assign bus.rd_start  = rd_start_q;
  assign bus.rd_bank   = rd_bank_q;
  assign bus.rd_n2     = rd_n2_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.busy      = (bank_q[0] != EMPTY) || (bank_q[1] != EMPTY);
  // writer only touches EMPTY/FILLING banks and the reader only FULL/READING ones, so updates never collide
  always_comb begin
    bank_d      = bank_q;
    len_d       = len_q;
    wr_cnt_d    = wr_cnt_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    rd_st_d     = rd_st_q;
    rd_start_d  = 1'b0;
    rd_bank_d   = rd_bank_q;
    rd_n2_d     = rd_n2_q;
    frame_cnt_d = frame_cnt_q;
    if (hs) begin
      len_d[wr_sel_q]  = cur_len;
      bank_d[wr_sel_q] = (wr_cnt_q == cur_len - 13'd1) ? FULL : FILLING;
      wr_cnt_d         = (wr_cnt_q == cur_len - 13'd1) ? '0 : wr_cnt_q + 13'd1;
      wr_sel_d         = (wr_cnt_q == cur_len - 13'd1) ? ~wr_sel_q : wr_sel_q;
    end
    if (rd_st_q == IDLE && bank_q[rd_sel_q] == FULL) begin
      rd_start_d       = 1'b1;
      rd_bank_d        = rd_sel_q;
      rd_n2_d          = len_q[rd_sel_q];
      bank_d[rd_sel_q] = READING;
      rd_st_d          = BUSY;
    end else if (rd_st_q == BUSY && bus.rd_done) begin
      bank_d[rd_sel_q] = EMPTY;
      rd_sel_d         = ~rd_sel_q;
      frame_cnt_d      = frame_cnt_q + 16'd1;
      rd_st_d          = IDLE;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bank_q      <= '{EMPTY, EMPTY};
      len_q       <= '{13'd0, 13'd0};
      wr_cnt_q    <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      rd_st_q     <= IDLE;
      rd_start_q  <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_n2_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      bank_q      <= bank_d;
      len_q       <= len_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      rd_st_q     <= rd_st_d;
      rd_start_q  <= rd_start_d;
      rd_bank_q   <= rd_bank_d;
      rd_n2_q     <= rd_n2_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb_fft_frame_scheduler: random-data directed scenarios checked against a frame-level scoreboard and reader model
module tb_fft_frame_scheduler;
  localparam int NFFT = 256;
  localparam int DW   = 32;
  typedef struct {logic b; int len; int wcyc;} frame_t;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic rd_done_r = 1'b0;
  logic rd_done_x = 1'b0;
  fft_frame_scheduler_if #(.DW(DW)) bus();
  fft_frame_scheduler #(.NFFT(NFFT), .DW(DW)) dut (.aclk(aclk), .aresetn(aresetn), .bus(bus.slave));
  assign bus.rd_done = rd_done_r | rd_done_x;
  always #5 aclk = ~aclk;
  int cyc = 0;
  always @(posedge aclk) cyc++;
  int n_chk = 0;
  int n_fail = 0;
  frame_t exp_q[$];
  logic [DW-1:0] sent[$];
  frame_t cur;
  logic m_bank = 1'b0;
  logic [1:0] m_held = 2'b00;
  logic busy_r = 1'b0;
  int m_cnt = 0, m_len = 0, m_frames = 0, last_done = -100, rd_dly = 256, rcnt = 0, e_cyc = 0;
  function automatic int eff(input int n);
    return (n == 0 || n > NFFT) ? NFFT : n;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // scoreboard plus reader model: frames are predicted from the sample stream, starts from completion/done times
  always @(negedge aclk) begin
    if (!aresetn) begin
      chk("s_tready_in_reset", bus.s_tready, 0);
      exp_q.delete();
      sent.delete();
      m_bank = 1'b0; m_held = 2'b00; m_cnt = 0; m_frames = 0;
      last_done = -100; busy_r = 1'b0; rd_done_r = 1'b0;
    end else begin
      chk("s_tready", bus.s_tready, !m_held[m_bank]);
      chk("wr_en", bus.wr_en, bus.s_tvalid && !m_held[m_bank]);
      chk("busy", bus.busy, (m_held != 2'b00) || (m_cnt != 0));
      chk("frame_cnt", bus.frame_cnt, m_frames[15:0]);
      rd_done_r = 1'b0;
      if (busy_r) begin
        chk("rd_start_while_reading", bus.rd_start, 0);
        chk("rd_bank_hold", bus.rd_bank, cur.b);
        chk("rd_n2_hold", bus.rd_n2, cur.len);
        if (rcnt == 0) begin
          rd_done_r = 1'b1;
          last_done = cyc;
          m_held[cur.b] = 1'b0;
          m_frames++;
          busy_r = 1'b0;
        end else rcnt--;
      end else if (exp_q.size() != 0) begin
        e_cyc = ((exp_q[0].wcyc > last_done) ? exp_q[0].wcyc : last_done) + 2;
        chk("rd_start_timing", bus.rd_start, cyc == e_cyc);
        if (bus.rd_start) begin
          cur = exp_q.pop_front();
          chk("rd_bank", bus.rd_bank, cur.b);
          chk("rd_n2", bus.rd_n2, cur.len);
          busy_r = 1'b1;
          rcnt = rd_dly - 1;
        end
      end else chk("rd_start_spurious", bus.rd_start, 0);
      if (bus.wr_en) begin
        if (m_cnt == 0) m_len = eff(int'(bus.N2));
        chk("wr_bank", bus.wr_bank, m_bank);
        chk("wr_addr", bus.wr_addr, m_cnt);
        if (sent.size() == 0) chk("wr_en_without_sample", bus.wr_en, 0);
        else chk("wr_data", bus.wr_data, sent.pop_front());
        m_cnt++;
        if (m_cnt == m_len) begin
          exp_q.push_back('{m_bank, m_len, cyc});
          m_held[m_bank] = 1'b1;
          m_bank = ~m_bank;
          m_cnt = 0;
        end
      end
    end
  end
  task automatic send(input int n, input int gap);
    int w;
    for (int i = 0; i < n; i++) begin
      w = 0;
      bus.s_tdata = $urandom;
      sent.push_back(bus.s_tdata);
      bus.s_tvalid = 1'b1;
      @(negedge aclk);
      while (!bus.s_tready && w < 3000) begin
        @(negedge aclk);
        w++;
      end
      if (w >= 3000) chk("s_tready_timeout", bus.s_tready, 1);
      @(posedge aclk);
      #1 bus.s_tvalid = 1'b0;
      repeat ($urandom_range(0, gap)) begin
        @(posedge aclk);
        #1;
      end
    end
  endtask
  task automatic wait_idle();
    int i;
    i = 0;
    while (!(exp_q.size() == 0 && !busy_r && m_cnt == 0) && i < 8000) begin
      @(posedge aclk);
      i++;
    end
    repeat (2) @(posedge aclk);
    #1;
    chk("idle_timeout", i < 8000, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int i;
    bus.N2 = 13'd100;
    bus.s_tvalid = 1'b0;
    bus.s_tdata = '0;
    #2;
    chk("rst_s_tready", bus.s_tready, 0);
    chk("rst_rd_start", bus.rd_start, 0);
    chk("rst_rd_bank", bus.rd_bank, 0);
    chk("rst_rd_n2", bus.rd_n2, 0);
    chk("rst_frame_cnt", bus.frame_cnt, 0);
    chk("rst_busy", bus.busy, 0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    rd_dly = 256;
    send(100, 0);
    wait_idle();
    chk("t1_frame_cnt", bus.frame_cnt, 1);
    bus.N2 = 13'd16;
    rd_dly = 300;
    send(64, 0);
    wait_idle();
    chk("t2_frame_cnt", bus.frame_cnt, 5);
    chk("t2_samples_left", sent.size(), 0);
    bus.N2 = 13'd0;
    rd_dly = $urandom_range(1, 40);
    send(256, 3);
    wait_idle();
    bus.N2 = 13'd300;
    send(256, 3);
    wait_idle();
    chk("t3_frame_cnt", bus.frame_cnt, 7);
    bus.N2 = 13'd50;
    rd_dly = $urandom_range(1, 80);
    send(10, 2);
    bus.N2 = 13'd20;
    send(60, 2);
    wait_idle();
    chk("t4_frame_cnt", bus.frame_cnt, 9);
    @(posedge aclk);
    #1 rd_done_x = 1'b1;
    @(posedge aclk);
    #1 rd_done_x = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("t6_frame_cnt", bus.frame_cnt, 9);
    chk("t6_busy", bus.busy, 0);
    bus.N2 = 13'd16;
    send(7, 0);
    bus.s_tvalid = 1'b1;
    aresetn = 1'b0;
    #1;
    chk("t5a_s_tready", bus.s_tready, 0);
    chk("t5a_wr_en", bus.wr_en, 0);
    chk("t5a_busy", bus.busy, 0);
    chk("t5a_frame_cnt", bus.frame_cnt, 0);
    bus.s_tvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    rd_dly = 30;
    send(32, 0);
    i = 0;
    while (!(busy_r && cur.b) && i < 2000) begin
      @(posedge aclk);
      i++;
    end
    chk("t5_second_read_timeout", i < 2000, 1);
    repeat (5) @(posedge aclk);
    #1 aresetn = 1'b0;
    #1;
    chk("t5b_rd_bank", bus.rd_bank, 0);
    chk("t5b_rd_n2", bus.rd_n2, 0);
    chk("t5b_rd_start", bus.rd_start, 0);
    chk("t5b_frame_cnt", bus.frame_cnt, 0);
    chk("t5b_busy", bus.busy, 0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (20) @(posedge aclk);
    #1;
    send(16, 0);
    wait_idle();
    chk("t5_frame_cnt", bus.frame_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
